// File: rtl/menu_screen_ctrl.sv
// menu_screen_ctrl: title/menu/game/pause screen sequencer with debounced keys and a menu cursor
// Ports:
//   CLOCK_50   - system clock, posedge
//   resetn     - asynchronous active-low reset (assert async, release synchronised)
//   KEY[3:0]   - raw active-low push-buttons
//   game_over  - level from game core, honoured only in GAME
//   screen     - 00 TITLE, 01 MENU, 10 GAME, 11 PAUSE
//   background - registered colour of the current screen
//   sel_idx    - menu cursor; sel_onehot is its one-hot decode
//   start      - one-cycle pulse on MENU -> GAME
//   item_sel   - one-cycle pulse when a non-zero menu entry is chosen
//   paused     - high while in PAUSE
module menu_screen_ctrl #(
    parameter int              N_ITEMS    = 3,
    parameter int              DEB_CYCLES = 500000,
    parameter int              BG_W       = 12,
    parameter logic [BG_W-1:0] BG_TITLE   = 12'h077,
    parameter logic [BG_W-1:0] BG_MENU    = 12'h770,
    parameter logic [BG_W-1:0] BG_GAME    = 12'h070,
    parameter logic [BG_W-1:0] BG_PAUSE   = 12'h333
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [3:0]                 KEY,
    input  logic                       game_over,
    output logic [1:0]                 screen,
    output logic [BG_W-1:0]            background,
    output logic [$clog2(N_ITEMS)-1:0] sel_idx,
    output logic [N_ITEMS-1:0]         sel_onehot,
    output logic                       start,
    output logic                       item_sel,
    output logic                       paused
);
    localparam int SW = $clog2(N_ITEMS);
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_TITLE = 2'b00,
        S_MENU  = 2'b01,
        S_GAME  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    logic [1:0]         r_rst_s;
    logic               w_rst_n;
    logic [3:0]         r_sync1, r_sync2, r_deb, r_arm, r_press;
    logic [3:0]         w_flip, w_act;
    logic [CW-1:0]      r_cnt [4];
    state_t             r_state, w_state_n;
    logic [SW-1:0]      r_sel, w_sel_n;
    logic               w_start_n, w_item_n;
    logic [BG_W-1:0]    r_bg;
    logic [N_ITEMS-1:0] r_onehot;
    logic               r_start, r_item, r_paused;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge resetn)
        if (!resetn) r_rst_s <= 2'b00;
        else         r_rst_s <= {r_rst_s[0], 1'b1};

    assign w_rst_n = r_rst_s[1];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_key
            assign w_flip[g] = (r_sync2[g] != r_deb[g]) && (r_cnt[g] == CW'(DEB_CYCLES - 1));
            always_ff @(posedge CLOCK_50 or negedge w_rst_n)
                if (!w_rst_n)                              r_cnt[g] <= '0;
                else if (r_sync2[g] == r_deb[g] || w_flip[g]) r_cnt[g] <= '0;
                else                                       r_cnt[g] <= r_cnt[g] + CW'(1);
        end
    endgenerate

    // Synchronisers reset to "pressed" so a key only arms once it has really been seen
    // released after reset; a key held through reset therefore never produces a press.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n)
        if (!w_rst_n) begin
            r_sync1 <= 4'h0;
            r_sync2 <= 4'h0;
            r_deb   <= 4'hF;
            r_arm   <= 4'h0;
            r_press <= 4'h0;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
            r_deb   <= r_deb ^ w_flip;
            r_arm   <= r_arm | r_sync2;
            r_press <= w_flip & r_deb & r_arm;
        end

    // Only the highest-priority key acts: KEY[2] > KEY[3] > KEY[0] > KEY[1].
    assign w_act = r_press[2] ? 4'b0100 :
                   r_press[3] ? 4'b1000 :
                   r_press[0] ? 4'b0001 :
                   r_press[1] ? 4'b0010 : 4'b0000;

    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_start_n = 1'b0;
        w_item_n  = 1'b0;
        case (r_state)
            S_TITLE: if (|w_act) begin
                w_state_n = S_MENU;
                w_sel_n   = '0;
            end
            S_MENU: begin
                if (w_act[0])
                    w_sel_n = (r_sel == SW'(N_ITEMS - 1)) ? '0 : r_sel + SW'(1);
                else if (w_act[1])
                    w_sel_n = (r_sel == '0) ? SW'(N_ITEMS - 1) : r_sel - SW'(1);
                else if (w_act[2] && r_sel == '0) begin
                    w_state_n = S_GAME;
                    w_start_n = 1'b1;
                end else if (w_act[2])
                    w_item_n = 1'b1;
            end
            S_GAME: begin
                if (game_over) begin
                    w_state_n = S_MENU;
                    w_sel_n   = '0;
                end else if (w_act[3])
                    w_state_n = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_act[3])
                    w_state_n = S_GAME;
                else if (w_act[2]) begin
                    w_state_n = S_MENU;
                    w_sel_n   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n)
        if (!w_rst_n) begin
            r_state  <= S_TITLE;
            r_sel    <= '0;
            r_bg     <= BG_TITLE;
            r_onehot <= N_ITEMS'(1);
            r_start  <= 1'b0;
            r_item   <= 1'b0;
            r_paused <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_sel    <= w_sel_n;
            r_bg     <= w_state_n == S_TITLE ? BG_TITLE :
                        w_state_n == S_MENU  ? BG_MENU  :
                        w_state_n == S_GAME  ? BG_GAME  : BG_PAUSE;
            r_onehot <= N_ITEMS'(1) << w_sel_n;
            r_start  <= w_start_n;
            r_item   <= w_item_n;
            r_paused <= w_state_n == S_PAUSE;
        end

    assign screen     = r_state;
    assign background = r_bg;
    assign sel_idx    = r_sel;
    assign sel_onehot = r_onehot;
    assign start      = r_start;
    assign item_sel   = r_item;
    assign paused     = r_paused;
endmodule
